// File: rtl/imm_ext_pkg.sv
// Shared constants for the ID-stage immediate generator: mode encodings,
// SHAMT field bounds and legal parameter ranges.
package imm_ext_pkg;

  localparam logic [2:0] MODE_ZERO   = 3'd0;
  localparam logic [2:0] MODE_SIGN   = 3'd1;
  localparam logic [2:0] MODE_UPPER  = 3'd2;
  localparam logic [2:0] MODE_BRANCH = 3'd3;
  localparam logic [2:0] MODE_SHAMT  = 3'd4;

  // Shift-amount field position inside the raw immediate
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned SHAMT_W  = SHAMT_HI - SHAMT_LO + 1;

  // Legal parameter ranges (IN_W upper bound is OUT_W/2, checked at the top)
  localparam int unsigned IN_W_MIN   = SHAMT_HI + 1;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: raw field + mode -> OUT_W result.
// Reserved modes yield a zero result with the illegal flag raised.
module imm_extend_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  output logic [OUT_W-1:0] result,
  output logic             illegal
);

  localparam int unsigned PAD_W = OUT_W - IN_W;

  logic             sign;
  logic [OUT_W-1:0] sext;

  assign sign = in_imm[IN_W-1];
  assign sext = {{PAD_W{sign}}, in_imm};

  // Mode decode; upper bits of SIGN/BRANCH replicate the sign bit
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (in_mode)
      MODE_ZERO:   result = {{PAD_W{1'b0}}, in_imm};
      MODE_SIGN:   result = sext;
      MODE_UPPER:  result = {in_imm, {PAD_W{1'b0}}};
      MODE_BRANCH: result = {sext[OUT_W-3:0], 2'b00};
      MODE_SHAMT:  result = {{(OUT_W-SHAMT_W){1'b0}}, in_imm[SHAMT_HI:SHAMT_LO]};
      default:     illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: extension core followed by a STAGES-deep
// register chain, each stage carrying {valid, data, illegal}. Flush wins over
// stall; reset clears every stage asynchronously.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_imm,
  output logic             out_illegal
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
      IN_W < IN_W_MIN || IN_W > OUT_W / 2) begin : g_param_check
    $fatal(1, "imm_extend_pipe: STAGES or IN_W outside legal range");
  end

  logic [OUT_W-1:0] core_result;
  logic             core_illegal;

  imm_extend_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_imm  (in_imm),
    .in_mode (in_mode),
    .result  (core_result),
    .illegal (core_illegal)
  );

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             valid_d, valid_q;
    logic [OUT_W-1:0] data_d,  data_q;
    logic             illegal_d, illegal_q;

    if (k == 0) begin : g_head
      // A cycle without a live instruction enters as an all-zero bubble
      assign valid_d   = in_valid;
      assign data_d    = in_valid ? core_result : '0;
      assign illegal_d = in_valid & core_illegal;
    end else begin : g_tail
      assign valid_d   = g_stage[k-1].valid_q;
      assign data_d    = g_stage[k-1].data_q;
      assign illegal_d = g_stage[k-1].illegal_q;
    end

    // Stage register: async clear, flush kills, stall holds, else capture
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        valid_q   <= 1'b0;
        data_q    <= '0;
        illegal_q <= 1'b0;
      end else if (flush) begin
        valid_q   <= 1'b0;
        data_q    <= '0;
        illegal_q <= 1'b0;
      end else if (!stall) begin
        valid_q   <= valid_d;
        data_q    <= data_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign out_valid   = g_stage[STAGES-1].valid_q;
  assign out_imm     = g_stage[STAGES-1].data_q;
  assign out_illegal = g_stage[STAGES-1].illegal_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 1-stage and a 3-stage instance share stimulus;
// each is compared against a queue-based delay-line reference model.
module tb_imm_extend_pipe;

  localparam bit [2:0] M_ZERO = 3'd0, M_SIGN = 3'd1, M_UPPER = 3'd2,
                       M_BRANCH = 3'd3, M_SHAMT = 3'd4;

  logic        Clk = 1'b0;
  logic        Reset, in_valid, stall, flush;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic        v1, il1, v3, il3;
  logic [31:0] d1, d3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        v;
    bit [31:0] d;
    bit        ill;
  } ent_t;

  ent_t q1[$];
  ent_t q3[$];

  always #5 Clk = ~Clk;

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_imm(in_imm),
    .in_mode(in_mode), .stall(stall), .flush(flush),
    .out_valid(v1), .out_imm(d1), .out_illegal(il1)
  );

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .STAGES(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_imm(in_imm),
    .in_mode(in_mode), .stall(stall), .flush(flush),
    .out_valid(v3), .out_imm(d3), .out_illegal(il3)
  );

  // Arithmetic reference for the extension modes
  function automatic ent_t ref_ext(bit [15:0] imm, bit [2:0] mode);
    ent_t e;
    int   s;
    s     = $signed(imm);
    e.v   = 1'b1;
    e.ill = 1'b0;
    case (mode)
      M_ZERO:   e.d = imm;
      M_SIGN:   e.d = s;
      M_UPPER:  e.d = imm * 32'd65536;
      M_BRANCH: e.d = s * 4;
      M_SHAMT:  e.d = (imm / 64) % 32;
      default: begin e.d = 0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic ent_t bubble();
    ent_t e;
    e.v = 1'b0; e.d = 0; e.ill = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    q1.delete();
    q3.delete();
    q1.push_back(bubble());
    repeat (3) q3.push_back(bubble());
  endtask

  // Applied at each rising edge with the inputs that were present
  task automatic model_edge();
    ent_t e;
    e = in_valid ? ref_ext(in_imm, in_mode) : bubble();
    if (flush) begin
      model_reset();
    end else if (!stall) begin
      q1.push_back(e); void'(q1.pop_front());
      q3.push_back(e); void'(q3.pop_front());
    end
  endtask

  task automatic cycle(input bit v, input bit [15:0] imm, input bit [2:0] mode,
                       input bit st, input bit fl);
    in_valid = v; in_imm = imm; in_mode = mode; stall = st; flush = fl;
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1; in_valid = 0; in_imm = 0; in_mode = 0; stall = 0; flush = 0;
    #2;
    checks++;
    if (v1 !== 1'b0 || d1 !== 32'h0 || il1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_s1: got v=%0b imm=%h ill=%0b, expected 0/0/0", v1, d1, il1);
    end
    checks++;
    if (v3 !== 1'b0 || d3 !== 32'h0 || il3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_s3: got v=%0b imm=%h ill=%0b, expected 0/0/0", v3, d3, il3);
    end
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_modes();
    bit [2:0]  md[10] = '{M_SIGN, M_ZERO, M_UPPER, M_BRANCH, M_SHAMT, 3'd6,
                          3'd5, 3'd7, M_SIGN, M_SHAMT};
    bit [15:0] im[10] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF, 16'h07C0,
                          16'hABCD, 16'h7FFF, 16'h0001, 16'h7FFF, 16'hF83F};
    bit [31:0] ex[10] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC,
                          32'h0000001F, 32'h0, 32'h0, 32'h0, 32'h00007FFF, 32'h0};
    bit        il[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, im[i], md[i], 1'b0, 1'b0);
      checks++;
      if (v1 !== 1'b1 || d1 !== ex[i] || il1 !== il[i]) begin
        errors++;
        $display("FAIL modes[%0d] mode=%0d imm=%h: got v=%0b imm=%h ill=%0b, expected v=1 imm=%h ill=%0b",
                 i, md[i], im[i], v1, d1, il1, ex[i], il[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit        ev;
    bit [31:0] ed;
    cycle(1'b0, 16'h0, M_ZERO, 1'b0, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 5) cycle(1'b1, 16'(i), M_SIGN, 1'b0, 1'b0);
      else        cycle(1'b0, 16'hDEAD, M_SIGN, 1'b0, 1'b0);
      ev = (i >= 3 && i <= 7);
      ed = ev ? 32'(i - 2) : 32'h0;
      checks++;
      if (v3 !== ev || d3 !== ed || il3 !== 1'b0) begin
        errors++;
        $display("FAIL back_to_back s3 cycle %0d: got v=%0b imm=%h, expected v=%0b imm=%h",
                 i, v3, d3, ev, ed);
      end
      checks++;
      if (v1 !== q1[0].v || d1 !== q1[0].d || il1 !== q1[0].ill) begin
        errors++;
        $display("FAIL back_to_back s1 cycle %0d: got v=%0b imm=%h, expected v=%0b imm=%h",
                 i, v1, d1, q1[0].v, q1[0].d);
      end
    end
  endtask

  task automatic test_stall();
    bit st;
    cycle(1'b0, 16'h0, M_ZERO, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      st = (k == 4 || k == 5);
      // Stalled cycles present a different value to prove inputs are ignored
      cycle(1'b1, st ? 16'hBEEF : 16'(16'h0100 + k), M_ZERO, st, 1'b0);
      checks++;
      if (v3 !== q3[0].v || d3 !== q3[0].d || il3 !== q3[0].ill) begin
        errors++;
        $display("FAIL stall s3 k=%0d: got v=%0b imm=%h, expected v=%0b imm=%h",
                 k, v3, d3, q3[0].v, q3[0].d);
      end
      checks++;
      if (v1 !== q1[0].v || d1 !== q1[0].d || il1 !== q1[0].ill) begin
        errors++;
        $display("FAIL stall s1 k=%0d: got v=%0b imm=%h, expected v=%0b imm=%h",
                 k, v1, d1, q1[0].v, q1[0].d);
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) cycle(1'b1, 16'(16'h0A00 + k), M_ZERO, 1'b0, 1'b0);
    cycle(1'b1, 16'h1111, M_SIGN, 1'b1, 1'b1);
    checks++;
    if (v1 !== 1'b0 || d1 !== 32'h0 || il1 !== 1'b0 ||
        v3 !== 1'b0 || d3 !== 32'h0 || il3 !== 1'b0) begin
      errors++;
      $display("FAIL flush: got s1 v=%0b imm=%h s3 v=%0b imm=%h, expected all zero",
               v1, d1, v3, d3);
    end
    cycle(1'b0, 16'h0, M_ZERO, 1'b0, 1'b0);
    checks++;
    if (v3 !== 1'b0 || d3 !== 32'h0) begin
      errors++;
      $display("FAIL flush_drain s3: got v=%0b imm=%h, expected v=0 imm=0", v3, d3);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    for (int k = 0; k < 3; k++) cycle(1'b1, 16'h0042, M_ZERO, 1'b0, 1'b0);
    checks++;
    if (v3 !== 1'b1 || d3 !== 32'h42) begin
      errors++;
      $display("FAIL pre_reset s3: got v=%0b imm=%h, expected v=1 imm=00000042", v3, d3);
    end
    // Pulse reset between edges, with a stall active
    stall = 1'b1;
    #3 Reset = 1'b1;
    #1;
    checks++;
    if (v1 !== 1'b0 || d1 !== 32'h0 || il1 !== 1'b0 ||
        v3 !== 1'b0 || d3 !== 32'h0 || il3 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got s1 v=%0b imm=%h s3 v=%0b imm=%h, expected all zero",
               v1, d1, v3, d3);
    end
    #1 Reset = 1'b0;
    model_reset();
    cycle(1'b1, 16'h0055, M_ZERO, 1'b0, 1'b0);
    checks++;
    if (v1 !== 1'b1 || d1 !== 32'h55) begin
      errors++;
      $display("FAIL post_reset s1: got v=%0b imm=%h, expected v=1 imm=00000055", v1, d1);
    end
    lat = 1;
    while (v3 !== 1'b1 && lat < 8) begin
      cycle(1'b0, 16'h0, M_ZERO, 1'b0, 1'b0);
      lat++;
    end
    checks++;
    if (lat != 3 || d3 !== 32'h55) begin
      errors++;
      $display("FAIL post_reset_latency s3: got %0d cycles imm=%h, expected 3 cycles imm=00000055",
               lat, d3);
    end
  endtask

  task automatic test_bubbles();
    bit        pat[6] = '{1, 0, 1, 1, 0, 1};
    bit [31:0] ed;
    cycle(1'b0, 16'h0, M_ZERO, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle(pat[i], 16'(16'h0300 + i), M_ZERO, 1'b0, 1'b0);
      ed = pat[i] ? 32'(16'h0300 + i) : 32'h0;
      checks++;
      if (v1 !== pat[i] || d1 !== ed || il1 !== 1'b0) begin
        errors++;
        $display("FAIL bubbles s1 i=%0d: got v=%0b imm=%h, expected v=%0b imm=%h",
                 i, v1, d1, pat[i], ed);
      end
      checks++;
      if (v3 !== q3[0].v || d3 !== q3[0].d || il3 !== q3[0].ill) begin
        errors++;
        $display("FAIL bubbles s3 i=%0d: got v=%0b imm=%h, expected v=%0b imm=%h",
                 i, v3, d3, q3[0].v, q3[0].d);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 7, 16'($urandom), 3'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      checks++;
      if (v1 !== q1[0].v || d1 !== q1[0].d || il1 !== q1[0].ill) begin
        errors++;
        $display("FAIL random s1 i=%0d: got v=%0b imm=%h ill=%0b, expected v=%0b imm=%h ill=%0b",
                 i, v1, d1, il1, q1[0].v, q1[0].d, q1[0].ill);
      end
      checks++;
      if (v3 !== q3[0].v || d3 !== q3[0].d || il3 !== q3[0].ill) begin
        errors++;
        $display("FAIL random s3 i=%0d: got v=%0b imm=%h ill=%0b, expected v=%0b imm=%h ill=%0b",
                 i, v3, d3, il3, q3[0].v, q3[0].d, q3[0].ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_stall();
    test_flush();
    test_async_reset();
    test_bubbles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
